// File: rtl/mac_hub_pkg.sv
// Shared constants and types for the MAC lookup hub: MAC width, FIFO entry
// layout and the lookup FSM state encoding.
package mac_hub_pkg;

  localparam int MAC_W   = 48;
  localparam int ENTRY_W = 2 * MAC_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } hub_state_e;

  typedef struct packed {
    logic [MAC_W-1:0] src;
    logic [MAC_W-1:0] dst;
  } mac_pair_t;

endpackage

// File: rtl/mac_hub_rr_arb.sv
// Round-robin grant over P_PORTS requesters. The search starts at the internal
// pointer, which moves to one past the winner whenever a grant is taken.
module mac_hub_rr_arb #(
  parameter int P_PORTS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [P_PORTS-1:0]         req,
  input  logic                       advance,
  output logic                       gnt_valid,
  output logic [$clog2(P_PORTS)-1:0] gnt_idx
);

  localparam int LW = $clog2(P_PORTS);

  logic [LW-1:0] rr_ptr;

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    // Scan from farthest to nearest so the closest requester is written last.
    for (int i = P_PORTS - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % P_PORTS]) begin
        gnt_valid = 1'b1;
        gnt_idx   = LW'((int'(rr_ptr) + i) % P_PORTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && gnt_valid) begin
      rr_ptr <= (int'(gnt_idx) == P_PORTS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock show-ahead FIFO, depth 2**P_ADDR_WIDTH. Pushes are ignored
// when full and pops are ignored when empty.
module sync_fifo_core #(
  parameter int P_DATA_WIDTH = 96,
  parameter int P_ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [P_DATA_WIDTH-1:0] wdata,
  output logic [P_DATA_WIDTH-1:0] rdata,
  output logic                    full,
  output logic                    empty
);

  localparam int DEPTH = 1 << P_ADDR_WIDTH;

  logic [P_DATA_WIDTH-1:0] mem [DEPTH];
  logic [P_ADDR_WIDTH:0]   wr_ptr;
  logic [P_ADDR_WIDTH:0]   rd_ptr;
  logic                    push_ok;
  logic                    pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full  = (wr_ptr[P_ADDR_WIDTH] != rd_ptr[P_ADDR_WIDTH]) &&
                 (wr_ptr[P_ADDR_WIDTH-1:0] == rd_ptr[P_ADDR_WIDTH-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[P_ADDR_WIDTH-1:0]];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define
  // validity, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[P_ADDR_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_lookup_hub.sv
// Multi-lane MAC lookup hub: per-lane request FIFOs, round-robin selection and
// a single outstanding lookup to the learning engine with timeout fallback.
module mac_lookup_hub
  import mac_hub_pkg::*;
#(
  parameter int P_PORTS      = 4,
  parameter int P_ADDR_WIDTH = 7,
  parameter int P_TIMEOUT    = 1023
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [P_PORTS-1:0]         req_valid_i,
  output logic [P_PORTS-1:0]         req_ready_o,
  input  logic [P_PORTS*48-1:0]      req_src_mac_i,
  input  logic [P_PORTS*48-1:0]      req_dst_mac_i,
  output logic                       lk_valid_o,
  input  logic                       lk_ready_i,
  output logic [47:0]                lk_src_mac_o,
  output logic [47:0]                lk_dst_mac_o,
  output logic [$clog2(P_PORTS)-1:0] lk_src_port_o,
  input  logic                       lk_done_i,
  input  logic [P_PORTS-1:0]         lk_dst_mask_i,
  output logic [P_PORTS-1:0]         rsp_valid_o,
  output logic [P_PORTS-1:0]         rsp_dst_mask_o,
  output logic                       rsp_timeout_o,
  output logic [15:0]                timeout_cnt_o
);

  localparam int LW = $clog2(P_PORTS);
  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT + 1) : 1;

  hub_state_e            state;
  logic [P_PORTS-1:0]    fifo_full;
  logic [P_PORTS-1:0]    fifo_empty;
  logic [P_PORTS-1:0]    fifo_pop;
  logic [ENTRY_W-1:0]    fifo_rdata [P_PORTS];
  logic                  gnt_valid;
  logic [LW-1:0]         gnt_idx;
  logic                  grant_fire;
  mac_pair_t             gnt_entry;
  logic [LW-1:0]         lane_q;
  logic [P_PORTS-1:0]    lane_bit;
  logic [TW-1:0]         wait_cnt;

  for (genvar g = 0; g < P_PORTS; g++) begin : g_lane
    sync_fifo_core #(
      .P_DATA_WIDTH (ENTRY_W),
      .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_fifo (
      .clk   (clk_i),
      .rst_n (rst_i),
      .push  (req_valid_i[g]),
      .pop   (fifo_pop[g]),
      .wdata ({req_src_mac_i[g*MAC_W +: MAC_W], req_dst_mac_i[g*MAC_W +: MAC_W]}),
      .rdata (fifo_rdata[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  mac_hub_rr_arb #(
    .P_PORTS (P_PORTS)
  ) u_arb (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .req       (~fifo_empty),
    .advance   (grant_fire),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Ready is taken from the pre-pop fill, so a full lane never sees push+pop.
  assign req_ready_o   = ~fifo_full;
  assign grant_fire    = (state == ST_IDLE) && gnt_valid;
  assign fifo_pop      = grant_fire ? (P_PORTS'(1) << gnt_idx) : '0;
  assign gnt_entry     = mac_pair_t'(fifo_rdata[gnt_idx]);
  assign lane_bit      = P_PORTS'(1) << lane_q;
  assign lk_src_port_o = lane_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= ST_IDLE;
      lane_q         <= '0;
      wait_cnt       <= '0;
      lk_valid_o     <= 1'b0;
      lk_src_mac_o   <= '0;
      lk_dst_mac_o   <= '0;
      rsp_valid_o    <= '0;
      rsp_dst_mask_o <= '0;
      rsp_timeout_o  <= 1'b0;
      timeout_cnt_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            lane_q       <= gnt_idx;
            lk_src_mac_o <= gnt_entry.src;
            lk_dst_mac_o <= gnt_entry.dst;
            lk_valid_o   <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (lk_ready_i) begin
            lk_valid_o <= 1'b0;
            wait_cnt   <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result arriving on the final count still beats the timeout.
          if (lk_done_i) begin
            rsp_dst_mask_o <= lk_dst_mask_i & ~lane_bit;
            rsp_valid_o    <= lane_bit;
            state          <= ST_RESP;
          end else if (wait_cnt == TW'(P_TIMEOUT - 1)) begin
            rsp_dst_mask_o <= ~lane_bit;
            rsp_valid_o    <= lane_bit;
            rsp_timeout_o  <= 1'b1;
            if (timeout_cnt_o != 16'hFFFF) timeout_cnt_o <= timeout_cnt_o + 1'b1;
            state          <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          rsp_valid_o   <= '0;
          rsp_timeout_o <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lookup_hub.sv
// Directed bench for mac_lookup_hub: basic lookup, hairpin removal, timeout,
// done-vs-timeout race, round-robin order, FIFO fill and mid-lookup reset.
module tb_mac_lookup_hub;

  localparam int NP = 4;

  logic              clk_i;
  logic              rst_i;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_ready_o;
  logic [NP*48-1:0]  req_src_mac_i;
  logic [NP*48-1:0]  req_dst_mac_i;
  logic              lk_valid_o;
  logic              lk_ready_i;
  logic [47:0]       lk_src_mac_o;
  logic [47:0]       lk_dst_mac_o;
  logic [1:0]        lk_src_port_o;
  logic              lk_done_i;
  logic [NP-1:0]     lk_dst_mask_i;
  logic [NP-1:0]     rsp_valid_o;
  logic [NP-1:0]     rsp_dst_mask_o;
  logic              rsp_timeout_o;
  logic [15:0]       timeout_cnt_o;

  int checks = 0;
  int errors = 0;

  mac_lookup_hub #(
    .P_PORTS      (NP),
    .P_ADDR_WIDTH (7),
    .P_TIMEOUT    (15)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_src_mac_i  (req_src_mac_i),
    .req_dst_mac_i  (req_dst_mac_i),
    .lk_valid_o     (lk_valid_o),
    .lk_ready_i     (lk_ready_i),
    .lk_src_mac_o   (lk_src_mac_o),
    .lk_dst_mac_o   (lk_dst_mac_o),
    .lk_src_port_o  (lk_src_port_o),
    .lk_done_i      (lk_done_i),
    .lk_dst_mask_i  (lk_dst_mask_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_dst_mask_o (rsp_dst_mask_o),
    .rsp_timeout_o  (rsp_timeout_o),
    .timeout_cnt_o  (timeout_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [47:0] mk_src(input int p, input int k);
    return {8'hA0, 8'(k), 24'h0, 8'(p)};
  endfunction

  function automatic logic [47:0] mk_dst(input int p, input int k);
    return {8'hD0, 8'(k), 24'h0, 8'(p)};
  endfunction

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic push_lanes(input logic [NP-1:0] mask, input int k);
    for (int p = 0; p < NP; p++) begin
      req_src_mac_i[p*48 +: 48] = mk_src(p, k);
      req_dst_mac_i[p*48 +: 48] = mk_dst(p, k);
    end
    req_valid_i = mask;
    tick();
    req_valid_i = '0;
  endtask

  task automatic wait_lk();
    for (int n = 0; n < 50 && !lk_valid_o; n++) tick();
    check("lk_valid_seen", 64'(lk_valid_o), 64'd1);
  endtask

  // One full lookup; the engine answers `delay` cycles after entering WAIT.
  task automatic lookup(input int port, input int delay, input logic [NP-1:0] eng_mask,
                        input logic [NP-1:0] exp_mask, input logic [47:0] exp_src,
                        input logic [47:0] exp_dst);
    wait_lk();
    check("lk_port", 64'(lk_src_port_o), 64'(port));
    check("lk_src",  64'(lk_src_mac_o), 64'(exp_src));
    check("lk_dst",  64'(lk_dst_mac_o), 64'(exp_dst));
    tick();
    repeat (delay) tick();
    lk_done_i     = 1'b1;
    lk_dst_mask_i = eng_mask;
    tick();
    lk_done_i     = 1'b0;
    lk_dst_mask_i = '0;
    check("rsp_valid",   64'(rsp_valid_o), 64'(4'b0001 << port));
    check("rsp_mask",    64'(rsp_dst_mask_o), 64'(exp_mask));
    check("rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    tick();
    check("rsp_pulse_end", 64'(rsp_valid_o), 64'd0);
  endtask

  initial begin
    logic seen;
    int   n;
    req_valid_i   = '0;
    req_src_mac_i = '0;
    req_dst_mac_i = '0;
    lk_ready_i    = 1'b1;
    lk_done_i     = 1'b0;
    lk_dst_mask_i = '0;
    rst_i         = 1'b1;
    #2;
    do_reset();

    check("rst_ready",   64'(req_ready_o), 64'hF);
    check("rst_lk_vld",  64'(lk_valid_o), 64'd0);
    check("rst_rsp_vld", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_msk", 64'(rsp_dst_mask_o), 64'd0);
    check("rst_rsp_to",  64'(rsp_timeout_o), 64'd0);
    check("rst_to_cnt",  64'(timeout_cnt_o), 64'd0);

    // Lane 2, engine answers on the second WAIT cycle with mask 0010.
    push_lanes(4'b0100, 1);
    lookup(2, 1, 4'b0010, 4'b0010, mk_src(2, 1), mk_dst(2, 1));

    // Lane 0 result pointing back at lane 0 is stripped to zero.
    push_lanes(4'b0001, 2);
    lookup(0, 0, 4'b0001, 4'b0000, mk_src(0, 2), mk_dst(0, 2));

    // Done while idle is ignored.
    seen = 1'b0;
    lk_done_i = 1'b1;
    lk_dst_mask_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid_o != 0 || lk_valid_o) seen = 1'b1;
    end
    lk_done_i = 1'b0;
    lk_dst_mask_i = '0;
    check("idle_done_ignored", 64'(seen), 64'd0);

    // Lane 1 with no answer: timeout after 15 WAIT cycles.
    push_lanes(4'b0010, 3);
    wait_lk();
    check("to_lk_port", 64'(lk_src_port_o), 64'd1);
    tick();
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rsp_valid_o != 0) seen = 1'b1;
    end
    check("to_no_early_rsp", 64'(seen), 64'd0);
    tick();
    check("to_rsp_valid", 64'(rsp_valid_o), 64'b0010);
    check("to_rsp_mask",  64'(rsp_dst_mask_o), 64'b1101);
    check("to_flag",      64'(rsp_timeout_o), 64'd1);
    check("to_cnt",       64'(timeout_cnt_o), 64'd1);
    tick();
    check("to_flag_clear", 64'(rsp_timeout_o), 64'd0);

    // Done on the timeout cycle wins; no timeout counted.
    push_lanes(4'b1000, 4);
    lookup(3, 14, 4'b0001, 4'b0001, mk_src(3, 4), mk_dst(3, 4));
    check("race_to_cnt", 64'(timeout_cnt_o), 64'd1);

    // Round-robin across all lanes from reset, two rounds.
    do_reset();
    push_lanes(4'b1111, 5);
    push_lanes(4'b1111, 6);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++)
        lookup(p, 0, 4'b0000, 4'b0000, mk_src(p, 5 + r), mk_dst(p, 5 + r));

    // Fill lane 3 with the engine stalled: one entry in flight plus 128 queued.
    do_reset();
    lk_ready_i = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (!req_ready_o[3]) break;
      req_src_mac_i[3*48 +: 48] = {16'h3A00, 32'(i)};
      req_dst_mac_i[3*48 +: 48] = {16'h3B00, 32'(i)};
      req_valid_i = 4'b1000;
      tick();
      n++;
    end
    req_valid_i = '0;
    check("fill_accepted", 64'(n), 64'd129);
    check("fill_ready",    64'(req_ready_o), 64'b0111);
    lk_ready_i = 1'b1;
    lookup(3, 0, 4'b0000, 4'b0000, {16'h3A00, 32'd0}, {16'h3B00, 32'd0});
    tick();
    check("fill_ready_after_pop", 64'(req_ready_o[3]), 64'd1);
    for (int i = 1; i < 129; i++)
      lookup(3, 0, 4'b0000, 4'b0000, {16'h3A00, 32'(i)}, {16'h3B00, 32'(i)});

    // Reset during WAIT: lookup discarded, pointer back to lane 0.
    push_lanes(4'b0100, 7);
    wait_lk();
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("mid_rst_lk_vld", 64'(lk_valid_o), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid_o != 0) seen = 1'b1;
    end
    rst_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid_o != 0 || lk_valid_o) seen = 1'b1;
    end
    check("mid_rst_no_rsp", 64'(seen), 64'd0);
    check("mid_rst_ready",  64'(req_ready_o), 64'hF);
    push_lanes(4'b1001, 8);
    lookup(0, 0, 4'b0000, 4'b0000, mk_src(0, 8), mk_dst(0, 8));
    lookup(3, 0, 4'b0000, 4'b0000, mk_src(3, 8), mk_dst(3, 8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
